// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD PHY arbiter: FSM state encoding and port indices.
package lcd_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] GRANT      = 2'd1;
  localparam logic [1:0] WAIT_FMARK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = IDLE,
    ST_GRANT      = GRANT,
    ST_WAIT_FMARK = WAIT_FMARK
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_phy_arb_wdog.sv
// Saturating idle counter; expire fires on the cycle whose increment would reach TIMEOUT.
module lcd_phy_arb_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_on
      assign expire = en && !clr && (cnt >= LIMIT_M1);
    end else begin : g_off
      logic unused_cnt;
      assign unused_cnt = ^cnt;
      assign expire     = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/lcd_phy_arb.sv
// Round-robin, transaction-granular arbiter of two byte sources onto one lcd_phy_raw port.
// Optional frame-mark alignment of transaction start: define LCD_PHY_ARB_FMARK_EN.
module lcd_phy_arb
  import lcd_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r0_rs,
  input  logic              r0_valid,
  input  logic              r0_last,
  input  logic              r0_sync,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r1_rs,
  input  logic              r1_valid,
  input  logic              r1_last,
  input  logic              r1_sync,
  output logic              r1_ready,
  output logic [DATA_W-1:0] phy_data,
  output logic              phy_rs,
  output logic              phy_valid,
  input  logic              phy_ready,
  input  logic              phy_fmark_stb,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_stb
);

  arb_state_t state, state_nx;
  logic [1:0] grant_nx;
  logic       prio, prio_nx;  // index of the port that wins a tie
  logic       stb_nx;
  logic       pick;
  logic       active, sel, gvalid, glast, xfer;
  logic       wd_clr, wd_en, expire;

  assign active = (state == ST_GRANT);
  assign sel    = grant[1];
  assign gvalid = sel ? r1_valid : r0_valid;
  assign glast  = sel ? r1_last  : r0_last;

  // Passthrough is gated outside GRANT so the PHY never sees stale bytes.
  assign phy_valid = active & gvalid;
  assign phy_data  = active ? (sel ? r1_data : r0_data) : '0;
  assign phy_rs    = active & (sel ? r1_rs : r0_rs);
  assign r0_ready  = active & grant[0] & phy_ready;
  assign r1_ready  = active & grant[1] & phy_ready;
  assign xfer      = phy_valid & phy_ready;

  assign wd_clr = (state == ST_IDLE) | (active & gvalid);
  assign wd_en  = active;

  lcd_phy_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (expire)
  );

  always_comb begin
    pick = PORT0;
    if (r0_valid && r1_valid) begin
      pick = prio;
    end else if (r1_valid) begin
      pick = PORT1;
    end
  end

`ifdef LCD_PHY_ARB_FMARK_EN
  logic pick_sync;
  assign pick_sync = (pick == PORT1) ? r1_sync : r0_sync;
`else
  logic unused_fmark;
  assign unused_fmark = ^{r0_sync, r1_sync, phy_fmark_stb};
`endif

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    prio_nx  = prio;
    stb_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (r0_valid || r1_valid) begin
          grant_nx = port_onehot(pick);
          prio_nx  = ~pick;
`ifdef LCD_PHY_ARB_FMARK_EN
          state_nx = pick_sync ? ST_WAIT_FMARK : ST_GRANT;
`else
          state_nx = ST_GRANT;
`endif
        end
      end
`ifdef LCD_PHY_ARB_FMARK_EN
      ST_WAIT_FMARK: begin
        if (phy_fmark_stb) begin
          state_nx = ST_GRANT;
        end
      end
`endif
      ST_GRANT: begin
        // A last transfer always clears the watchdog, so the two never coincide.
        if (xfer && glast) begin
          state_nx = ST_IDLE;
          grant_nx = '0;
        end else if (expire) begin
          state_nx = ST_IDLE;
          grant_nx = '0;
          stb_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      prio        <= PORT0;
      busy        <= 1'b0;
      timeout_stb <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      prio        <= prio_nx;
      busy        <= (state_nx != ST_IDLE);
      timeout_stb <= stb_nx;
    end
  end

endmodule

// File: tb/tb_lcd_phy_arb.sv
// Directed and randomized checks of lcd_phy_arb against a transaction-level expected stream.
`timescale 1ns/1ps
module tb_lcd_phy_arb;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] r0_data, r1_data;
  logic       r0_rs, r0_valid, r0_last, r0_sync, r0_ready;
  logic       r1_rs, r1_valid, r1_last, r1_sync, r1_ready;
  logic [7:0] phy_data;
  logic       phy_rs, phy_valid, phy_ready, phy_fmark_stb;
  logic [1:0] grant;
  logic       busy, timeout_stb;

  always #5 clk = ~clk;

  lcd_phy_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_data(r0_data), .r0_rs(r0_rs), .r0_valid(r0_valid), .r0_last(r0_last),
    .r0_sync(r0_sync), .r0_ready(r0_ready),
    .r1_data(r1_data), .r1_rs(r1_rs), .r1_valid(r1_valid), .r1_last(r1_last),
    .r1_sync(r1_sync), .r1_ready(r1_ready),
    .phy_data(phy_data), .phy_rs(phy_rs), .phy_valid(phy_valid), .phy_ready(phy_ready),
    .phy_fmark_stb(phy_fmark_stb), .grant(grant), .busy(busy), .timeout_stb(timeout_stb)
  );

  int tests = 0;
  int fails = 0;

  // Per-port pending bytes {last, rs, data}; expected PHY transfers {grant, rs, data}.
  logic [9:0]  q0[$];
  logic [9:0]  q1[$];
  logic [10:0] expq[$];
  bit          gap_en, rdy_rand;
  logic [7:0]  t1b[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    r0_data = '0; r0_rs = 0; r0_valid = 0; r0_last = 0; r0_sync = 0;
    r1_data = '0; r1_rs = 0; r1_valid = 0; r1_last = 0; r1_sync = 0;
    phy_ready = 1; phy_fmark_stb = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic gen_tx(input bit p);
    int len;
    logic [7:0] d;
    logic rs, last;
    len = $urandom_range(1, 5);
    for (int k = 0; k < len; k++) begin
      d = 8'($urandom);
      rs = (k != 0);
      last = (k == len - 1);
      if (p) q1.push_back({last, rs, d});
      else   q0.push_back({last, rs, d});
      expq.push_back({(p ? 2'b10 : 2'b01), rs, d});
    end
  endtask

  // Both ports queue all transactions up front, so ownership strictly alternates.
  task automatic build(input int n0, input int n1);
    for (int i = 0; i < ((n0 > n1) ? n0 : n1); i++) begin
      if (i < n0) gen_tx(1'b0);
      if (i < n1) gen_tx(1'b1);
    end
  endtask

  task automatic run_engine(input int max_cyc);
    int cyc = 0;
    int gap0 = 0, gap1 = 0;
    bit dead = 0;
    logic [10:0] e;
    while (expq.size() > 0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      phy_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (q0.size() > 0) begin
        {r0_last, r0_rs, r0_data} = q0[0];
        r0_valid = 1;
        if (gap_en && grant == 2'b01 && gap0 < 3 && $urandom_range(0, 3) == 0) begin
          r0_valid = 0; gap0++;
        end else gap0 = 0;
      end else begin
        r0_valid = 0; gap0 = 0;
      end
      if (q1.size() > 0) begin
        {r1_last, r1_rs, r1_data} = q1[0];
        r1_valid = 1;
        if (gap_en && grant == 2'b10 && gap1 < 3 && $urandom_range(0, 3) == 0) begin
          r1_valid = 0; gap1++;
        end else gap1 = 0;
      end else begin
        r1_valid = 0; gap1 = 0;
      end
      #1;
      if (dead) chk("eng_dead_cycle", grant, 0);
      dead = 0;
      chk("eng_no_timeout", timeout_stb, 0);
      if (phy_valid && phy_ready) begin
        e = expq.pop_front();
        chk("eng_xfer", {grant, phy_rs, phy_data}, e);
      end
      if (r0_valid && r0_ready) begin
        if (r0_last) dead = 1;
        void'(q0.pop_front());
      end
      if (r1_valid && r1_ready) begin
        if (r1_last) dead = 1;
        void'(q1.pop_front());
      end
    end
    chk("eng_drained", expq.size(), 0);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int k, cyc;
    t1b[0] = 8'h2A; t1b[1] = 8'h00; t1b[2] = 8'h00; t1b[3] = 8'h01; t1b[4] = 8'h3F;

    // Reset with both requests asserted: everything must stay at reset values.
    rst = 1;
    idle_inputs();
    r0_valid = 1; r1_valid = 1; r0_data = 8'h55; r1_data = 8'hAA; r0_rs = 1; r1_rs = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {grant, busy, timeout_stb}, 0);
    chk("rst_phy", {phy_valid, phy_rs, phy_data}, 0);
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    rst = 0;
    idle_inputs();

    // Port 0: command 0x2A plus four parameters.
    @(negedge clk);
    r0_valid = 1; r0_data = t1b[0]; r0_rs = 0; r0_last = 0;
    #1;
    chk("t1_idle", grant, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r0_data = t1b[i]; r0_rs = (i != 0); r0_last = (i == 4);
      #1;
      chk("t1_grant", {grant, busy, r0_ready}, 4'b0111);
      chk("t1_byte", {phy_valid, phy_rs, phy_data}, {1'b1, (i != 0), t1b[i]});
    end
    @(negedge clk);
    r0_valid = 0; r0_last = 0;
    #1;
    chk("t1_release", {grant, busy, phy_valid}, 0);

    // Simultaneous requests after reset: port 0 first, then strict alternation.
    do_reset();
    gap_en = 0; rdy_rand = 0;
    build(2, 2);
    run_engine(500);

    // Port 1 owns the PHY while port 0 toggles its request.
    do_reset();
    @(negedge clk);
    r1_valid = 1; r1_data = 8'h80; r1_rs = 1; r1_last = 0;
    k = 0; cyc = 0;
    while (k < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      r0_valid = cyc[0]; r0_data = 8'hEE; r0_rs = 1; r0_last = 1;
      phy_ready = 1'($urandom_range(0, 1));
      r1_data = 8'(8'h80 + k); r1_last = (k == 5);
      #1;
      chk("t3_owner", {grant, r0_ready}, 3'b100);
      if (phy_valid && phy_ready) begin
        chk("t3_byte", phy_data, 8'(8'h80 + k));
        k++;
      end
    end
    chk("t3_count", k, 6);
    @(negedge clk);
    r1_valid = 0; r1_last = 0; r0_valid = 1; phy_ready = 1;
    #1;
    chk("t3_dead", grant, 0);
    @(negedge clk);
    #1;
    chk("t3_p0", {grant, phy_valid, phy_data}, {2'b01, 1'b1, 8'hEE});
    @(negedge clk);
    r0_valid = 0;
    #1;
    chk("t3_end", grant, 0);

    // Watchdog: port 0 stalls mid-transaction while port 1 waits.
    do_reset();
    @(negedge clk);
    r0_valid = 1; r0_data = 8'hA0; r0_rs = 0; r0_last = 0;
    r1_valid = 1; r1_data = 8'hB0; r1_rs = 0; r1_last = 1;
    #1;
    @(negedge clk);
    #1;
    chk("t4_b0", {grant, phy_valid, phy_data}, {2'b01, 1'b1, 8'hA0});
    @(negedge clk);
    r0_data = 8'hA1; r0_rs = 1;
    #1;
    chk("t4_b1", {grant, phy_valid, phy_data}, {2'b01, 1'b1, 8'hA1});
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      r0_valid = 0;
      #1;
      chk("t4_hold", {grant, timeout_stb, phy_valid, r1_ready}, {2'b01, 3'b000});
    end
    @(negedge clk);
    #1;
    chk("t4_release", {grant, timeout_stb, busy}, 4'b0010);
    @(negedge clk);
    #1;
    chk("t4_p1", {grant, timeout_stb, phy_valid, phy_data}, {2'b10, 1'b0, 1'b1, 8'hB0});
    @(negedge clk);
    r1_valid = 0; r1_last = 0;
    #1;
    chk("t4_end", {grant, timeout_stb}, 0);

    // Frame-mark alignment (or its absence in the default build).
    do_reset();
    @(negedge clk);
    r0_valid = 1; r0_sync = 1; r0_data = 8'h5A; r0_rs = 1; r0_last = 1; phy_fmark_stb = 1;
    #1;
`ifdef LCD_PHY_ARB_FMARK_EN
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      phy_fmark_stb = (i == 40);
      #1;
      chk("t5_wait", {phy_valid, timeout_stb, r0_ready, phy_data}, 0);
    end
    @(negedge clk);
    phy_fmark_stb = 0;
    #1;
    chk("t5_first", {grant, phy_valid, phy_data}, {2'b01, 1'b1, 8'h5A});
`else
    @(negedge clk);
    phy_fmark_stb = 0;
    #1;
    chk("t5_nosync", {grant, phy_valid, phy_data}, {2'b01, 1'b1, 8'h5A});
`endif
    @(negedge clk);
    r0_valid = 0; r0_sync = 0; r0_last = 0;
    #1;
    chk("t5_end", {grant, timeout_stb}, 0);

    // Reset during a stalled grant; port-0 preference must be restored.
    do_reset();
    @(negedge clk);
    r0_valid = 1; r0_data = 8'hC0; r0_last = 0;
    r1_valid = 1; r1_data = 8'hD0; r1_last = 1;
    phy_ready = 0;
    #1;
    @(negedge clk);
    #1;
    chk("t6_granted", {grant, phy_valid, r0_ready}, 4'b0110);
    @(negedge clk);
    rst = 1;
    #1;
    @(negedge clk);
    rst = 0; phy_ready = 1;
    #1;
    chk("t6_rst_ctrl", {grant, busy, timeout_stb}, 0);
    chk("t6_rst_phy", {phy_valid, phy_rs, phy_data, r0_ready, r1_ready}, 0);
    @(negedge clk);
    #1;
    chk("t6_prio", {grant, phy_data}, {2'b01, 8'hC0});

    // Randomized traffic with stalls and request gaps.
    do_reset();
    gap_en = 1; rdy_rand = 1;
    build(6, 6);
    run_engine(3000);
    build(3, 6);
    run_engine(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
